multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/riscv_ctrl_pkg.sv | 32 +++
 rtl/multicycle_ctrl_if.sv | 48 ++++
 rtl/mc_wait_timer.sv | 37 +++
 rtl/multicycle_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle controller slice.
// Holds the FSM state enumeration, the RV32 major opcodes that the controller
// understands, the alu_op encodings it drives, and a small helper that
// classifies an opcode as one the controller can execute.
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_FAULT  = 3'd6
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // Anything outside these four major opcodes has no datapath sequence here,
  // so decode sends it to the fault state.
  function automatic logic isLegalOp(input logic [6:0] op);
    return (op == OP_R) || (op == OP_LOAD) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Bundle of the controller's datapath/memory-facing signals.
// master : the controller side (samples opcode/zero/mem_ready, drives controls)
// slave  : the datapath/memory side
// Inputs to controller : opcode[6:0], zero, mem_ready
// Outputs of controller: mem_req, iord, ir_write, pc_write, branch, mem_read,
//                        mem_to_reg, mem_write, alu_src, reg_write,
//                        alu_op[1:0], fault, state[2:0]
// Optional (MC_CTRL_INSTRET_EN defined): instret[31:0] retired-instruction count
interface multicycle_ctrl_if;
  logic [6:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        mem_req;
  logic        iord;
  logic        ir_write;
  logic        pc_write;
  logic        branch;
  logic        mem_read;
  logic        mem_to_reg;
  logic        mem_write;
  logic        alu_src;
  logic        reg_write;
  logic [1:0]  alu_op;
  logic        fault;
  logic [2:0]  state;
`ifdef MC_CTRL_INSTRET_EN
  logic [31:0] instret;
`endif

  modport master (
    input  opcode, zero, mem_ready,
    output mem_req, iord, ir_write, pc_write, branch, mem_read, mem_to_reg,
           mem_write, alu_src, reg_write, alu_op, fault, state
`ifdef MC_CTRL_INSTRET_EN
    , output instret
`endif
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  mem_req, iord, ir_write, pc_write, branch, mem_read, mem_to_reg,
           mem_write, alu_src, reg_write, alu_op, fault, state
`ifdef MC_CTRL_INSTRET_EN
    , input instret
`endif
  );

endinterface

// File: rtl/mc_wait_timer.sv
// Memory wait-state timer for the multicycle controller.
// Counts cycles spent waiting on mem_ready and flags the cycle in which the
// wait has reached WAIT_MAX while memory is still not ready.
// Ports: clk, rst_n (async active-low), clr (restart count), en (an access is
//        in progress), ready (memory completion), expired (timeout this cycle)
module mc_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic ready,
  output logic expired
);

  localparam int CW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

  logic [CW-1:0] r_count;

  // The count only advances on cycles where an access is pending and memory
  // has not answered; a restart always wins so each new access starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en && !ready) begin
      r_count <= r_count + CW'(1);
    end
  end

  // A ready arriving in the limit cycle masks the timeout, so a late but
  // successful access still completes.
  assign expired = en && !ready && (r_count == CW'(WAIT_MAX));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V main controller: sequences IDLE, FETCH, DECODE, EXEC,
// MEM, WB and a terminal FAULT state and drives the datapath controls.
// Ports: clk (rising-edge clock), rst_n (async active-low reset),
//        bus (multicycle_ctrl_if.master: opcode/zero/mem_ready in, controls out)
// Parameter: WAIT_MAX, the longest memory wait tolerated before faulting.
// Optional feature: define MC_CTRL_INSTRET_EN to add the instret counter.
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  multicycle_ctrl_if.master bus
);

  state_e     r_state;
  state_e     w_nextState;
  logic [6:0] r_opQ;
  logic       r_runEn;
  logic       w_inAccess;
  logic       w_timerClr;
  logic       w_expired;
  logic       w_memReq, w_iord, w_irWrite, w_pcWrite, w_branch, w_memRead;
  logic       w_memToReg, w_memWrite, w_aluSrc, w_regWrite, w_fault;
  logic [1:0] w_aluOp;

  // r_runEn stays low for the first edge after reset release, which holds
  // IDLE one extra cycle so the first FETCH starts on the second edge.
  // op_q is captured only while in DECODE so EXEC/MEM/WB see a stable opcode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_opQ   <= '0;
      r_runEn <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_runEn <= 1'b1;
      if (r_state == ST_DECODE) begin
        r_opQ <= bus.opcode;
      end
    end
  end

  // Next-state and control decode. Everything defaults to idle-low so that
  // IDLE, DECODE and FAULT only need to name what differs. mem_ready and zero
  // are looked at solely in the states that use them.
  always_comb begin
    w_nextState = r_state;
    w_memReq    = 1'b0;
    w_iord      = 1'b0;
    w_irWrite   = 1'b0;
    w_pcWrite   = 1'b0;
    w_branch    = 1'b0;
    w_memRead   = 1'b0;
    w_memToReg  = 1'b0;
    w_memWrite  = 1'b0;
    w_aluSrc    = 1'b0;
    w_regWrite  = 1'b0;
    w_aluOp     = ALU_ADD;
    w_fault     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_runEn) w_nextState = ST_FETCH;
      end
      ST_FETCH: begin
        w_memReq  = 1'b1;
        w_memRead = 1'b1;
        if (bus.mem_ready) begin
          w_irWrite   = 1'b1;
          w_pcWrite   = 1'b1;
          w_nextState = ST_DECODE;
        end else if (w_expired) begin
          w_nextState = ST_FAULT;
        end
      end
      ST_DECODE: begin
        w_nextState = isLegalOp(bus.opcode) ? ST_EXEC : ST_FAULT;
      end
      ST_EXEC: begin
        case (r_opQ)
          OP_R: begin
            w_aluOp     = ALU_FUNCT;
            w_nextState = ST_WB;
          end
          OP_LOAD, OP_STORE: begin
            w_aluSrc    = 1'b1;
            w_nextState = ST_MEM;
          end
          OP_BRANCH: begin
            w_aluOp     = ALU_SUB;
            w_branch    = 1'b1;
            w_pcWrite   = bus.zero;
            w_nextState = ST_FETCH;
          end
          default: w_nextState = ST_FAULT;
        endcase
      end
      ST_MEM: begin
        w_memReq   = 1'b1;
        w_iord     = 1'b1;
        w_memRead  = (r_opQ == OP_LOAD);
        w_memWrite = (r_opQ == OP_STORE);
        if (bus.mem_ready) begin
          w_nextState = (r_opQ == OP_LOAD) ? ST_WB : ST_FETCH;
        end else if (w_expired) begin
          w_nextState = ST_FAULT;
        end
      end
      ST_WB: begin
        w_regWrite  = 1'b1;
        w_memToReg  = (r_opQ == OP_LOAD);
        w_nextState = ST_FETCH;
      end
      ST_FAULT: begin
        w_fault = 1'b1;
      end
      default: w_nextState = ST_FAULT;
    endcase
  end

  // The timer restarts whenever a fresh memory access begins, including the
  // MEM-to-FETCH hop after a store, and only counts while one is pending.
  assign w_inAccess = (r_state == ST_FETCH) || (r_state == ST_MEM);
  assign w_timerClr = ((w_nextState == ST_FETCH) || (w_nextState == ST_MEM)) &&
                      (w_nextState != r_state);

  mc_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_waitTimer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (w_timerClr),
    .en      (w_inAccess),
    .ready   (bus.mem_ready),
    .expired (w_expired)
  );

  assign bus.mem_req    = w_memReq;
  assign bus.iord       = w_iord;
  assign bus.ir_write   = w_irWrite;
  assign bus.pc_write   = w_pcWrite;
  assign bus.branch     = w_branch;
  assign bus.mem_read   = w_memRead;
  assign bus.mem_to_reg = w_memToReg;
  assign bus.mem_write  = w_memWrite;
  assign bus.alu_src    = w_aluSrc;
  assign bus.reg_write  = w_regWrite;
  assign bus.alu_op     = w_aluOp;
  assign bus.fault      = w_fault;
  assign bus.state      = r_state;

`ifdef MC_CTRL_INSTRET_EN
  logic [31:0] r_instret;

  // An instruction retires when control returns to FETCH from any execution
  // state; the counter wraps naturally at 32 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instret <= '0;
    end else if ((w_nextState == ST_FETCH) &&
                 ((r_state == ST_EXEC) || (r_state == ST_MEM) || (r_state == ST_WB))) begin
      r_instret <= r_instret + 32'd1;
    end
  end

  assign bus.instret = r_instret;
`endif

endmodule
